// File: rtl/me_pkg.sv
// Shared types and constants for the motion-estimation PE schedule controller.
package me_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DATA_PRE = 3'd1,
    ST_AREA1    = 3'd2,
    ST_AREA2    = 3'd3,
    ST_AREA3    = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    AREA_1 = 2'd0,
    AREA_2 = 2'd1,
    AREA_3 = 2'd2
  } area_e;

  localparam int ABS_ACC_BIT  = 0;
  localparam int ABS_PASS_BIT = 1;

  localparam int DEF_PRE_CYCLES = 64;
  localparam int DEF_ROWS       = 38;
  localparam int DEF_HEAD_ROWS  = 8;
  localparam int DEF_TAIL_START = 34;
  localparam int DEF_NUM_COLS   = 32;
  localparam int DEF_EDGE_COLS  = 8;
  localparam int DEF_STRIDE     = 8;

  function automatic state_e area_to_state(input area_e a);
    case (a)
      AREA_1:  return ST_AREA1;
      AREA_2:  return ST_AREA2;
      default: return ST_AREA3;
    endcase
  endfunction

endpackage

// File: rtl/me_col_area_decode.sv
// Combinational map from search column index to schedule area.
module me_col_area_decode
  import me_pkg::*;
#(
  parameter int NUM_COLS  = DEF_NUM_COLS,
  parameter int EDGE_COLS = DEF_EDGE_COLS,
  parameter int STRIDE    = DEF_STRIDE,
  parameter int COL_W     = $clog2(NUM_COLS)
) (
  input  logic [COL_W-1:0] col,
  output area_e            area
);

  logic [31:0] col_ext;
  logic [31:0] rel;

  always_comb begin
    col_ext = 32'(col);
    rel     = col_ext - 32'(EDGE_COLS);
    area    = AREA_3;
    // Window edges take precedence; rel is only meaningful for interior columns.
    if (col_ext < 32'(EDGE_COLS) || col_ext >= 32'(NUM_COLS - EDGE_COLS)) begin
      area = AREA_1;
    end else if ((rel % 32'(STRIDE)) == 32'd0) begin
      area = AREA_2;
    end
  end

endmodule

// File: rtl/me_pe_sched_ctrl.sv
// PE-array schedule controller: current-block preload, then per-column two-pass row schedule.
// Optional macro ME_SAD_DOWNSAMPLE_EN enables the alternating accumulate/shift pattern in AREA1.
module me_pe_sched_ctrl
  import me_pkg::*;
#(
  parameter int PRE_CYCLES = DEF_PRE_CYCLES,
  parameter int ROWS       = DEF_ROWS,
  parameter int HEAD_ROWS  = DEF_HEAD_ROWS,
  parameter int TAIL_START = DEF_TAIL_START,
  parameter int NUM_COLS   = DEF_NUM_COLS,
  parameter int EDGE_COLS  = DEF_EDGE_COLS,
  parameter int STRIDE     = DEF_STRIDE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic                        in_curr_enable,
  output logic                        cb_select,
  output logic [1:0]                  abs_control,
  output logic                        change_ref,
  output logic                        ref_input_control,
  output logic [$clog2(NUM_COLS)-1:0] col_idx
);

  localparam int COL_W = $clog2(NUM_COLS);
  localparam int PRE_W = $clog2(PRE_CYCLES + 1);
  localparam int ROW_W = $clog2(ROWS + 1);

`ifdef ME_SAD_DOWNSAMPLE_EN
  localparam bit DS_EN = 1'b1;
`else
  localparam bit DS_EN = 1'b0;
`endif

  if (HEAD_ROWS >= TAIL_START || TAIL_START > ROWS || (PRE_CYCLES % 2) != 0 ||
      2 * EDGE_COLS > NUM_COLS || STRIDE < 1) begin : g_param_err
    $error("me_pe_sched_ctrl: illegal parameter combination");
  end

  state_e             state_q, state_raw, state_d;
  logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               pass_q, pass_d;
  logic [COL_W-1:0]   col_q, col_d;
  area_e              area_d;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ice_q, ice_d;
  logic               cb_q, cb_d;
  logic [1:0]         abs_q, abs_d;
  logic               cr_q, cr_d;
  logic               ric_q, ric_d;

  logic               head, tail, acc, shift;

  me_col_area_decode #(
    .NUM_COLS (NUM_COLS),
    .EDGE_COLS(EDGE_COLS),
    .STRIDE   (STRIDE),
    .COL_W    (COL_W)
  ) u_area (
    .col (col_d),
    .area(area_d)
  );

  // Next state and counters; area states are refined from the next column below.
  always_comb begin
    state_raw = state_q;
    pre_cnt_d = pre_cnt_q;
    row_d     = row_q;
    pass_d    = pass_q;
    col_d     = col_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_raw = ST_DATA_PRE;
      end
      ST_DATA_PRE: begin
        if (pre_cnt_q == PRE_W'(PRE_CYCLES - 1)) begin
          state_raw = ST_AREA1;
          pre_cnt_d = '0;
        end else begin
          pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end
      end
      ST_AREA1, ST_AREA2, ST_AREA3: begin
        if (row_q == ROW_W'(ROWS - 1)) begin
          row_d = '0;
          if (pass_q) begin
            pass_d = 1'b0;
            if (col_q == COL_W'(NUM_COLS - 1)) state_raw = ST_DONE;
            else                               col_d     = col_q + COL_W'(1);
          end else begin
            pass_d = 1'b1;
          end
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end
      ST_DONE: state_raw = ST_IDLE;
      default: state_raw = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) state_raw = ST_IDLE;
    if (state_raw == ST_IDLE) begin
      pre_cnt_d = '0;
      row_d     = '0;
      pass_d    = 1'b0;
      col_d     = '0;
    end
  end

  // Outputs are computed from the next state so they register in step with it.
  always_comb begin
    state_d = state_raw;
    if (state_raw inside {ST_AREA1, ST_AREA2, ST_AREA3}) state_d = area_to_state(area_d);

    head  = row_d < ROW_W'(HEAD_ROWS);
    tail  = row_d >= ROW_W'(TAIL_START);
    acc   = 1'b0;
    shift = 1'b0;

    busy_d = state_d != ST_IDLE;
    done_d = 1'b0;
    ice_d  = 1'b0;
    cb_d   = 1'b1;
    abs_d  = 2'b00;
    cr_d   = 1'b0;
    ric_d  = 1'b0;

    case (state_d)
      ST_DATA_PRE: begin
        ice_d = 1'b1;
        cb_d  = pre_cnt_d < PRE_W'(PRE_CYCLES / 2);
      end
      ST_AREA1: begin
        acc   = !head && (tail || !DS_EN || !row_d[0]);
        shift = head || tail || !DS_EN || row_d[0];
      end
      ST_AREA2: begin
        acc   = !head;
        shift = 1'b1;
      end
      ST_AREA3: begin
        acc   = 1'b1;
        shift = row_d == ROW_W'(ROWS - 1);
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase

    if (state_d inside {ST_AREA1, ST_AREA2, ST_AREA3}) begin
      ric_d               = 1'b1;
      cb_d                = !pass_d;
      abs_d[ABS_PASS_BIT] = pass_d;
      abs_d[ABS_ACC_BIT]  = acc;
      cr_d                = shift;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pre_cnt_q <= '0;
      row_q     <= '0;
      pass_q    <= 1'b0;
      col_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ice_q     <= 1'b0;
      cb_q      <= 1'b1;
      abs_q     <= 2'b00;
      cr_q      <= 1'b0;
      ric_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      row_q     <= row_d;
      pass_q    <= pass_d;
      col_q     <= col_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ice_q     <= ice_d;
      cb_q      <= cb_d;
      abs_q     <= abs_d;
      cr_q      <= cr_d;
      ric_q     <= ric_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign in_curr_enable    = ice_q;
  assign cb_select         = cb_q;
  assign abs_control       = abs_q;
  assign change_ref        = cr_q;
  assign ref_input_control = ric_q;
  assign col_idx           = col_q;

endmodule

// File: tb/tb_me_pe_sched_ctrl.sv
// Self-checking bench for me_pe_sched_ctrl against a schedule-time reference model.
module tb_me_pe_sched_ctrl;

  localparam int PRE   = 64;
  localparam int ROWS  = 38;
  localparam int HEAD  = 8;
  localparam int TAILS = 34;
  localparam int NCOL  = 32;
  localparam int EDGE  = 8;
  localparam int STR   = 8;
  localparam int COLW  = 5;
  localparam int SCHED = NCOL * 2 * ROWS;
  localparam int TOTAL = PRE + SCHED;
  localparam logic [12:0] RST_VEC = {1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 5'd0};

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic busy, done, ice, cb, cr, ric;
  logic [1:0] abs_c;
  logic [COLW-1:0] col;

  int errors = 0;
  int checks = 0;

  // Model: active flag and time index t since the first preload cycle.
  bit m_active = 1'b0;
  int m_t = 0;

  always #5 clk = ~clk;

  me_pe_sched_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .in_curr_enable(ice), .cb_select(cb),
    .abs_control(abs_c), .change_ref(cr), .ref_input_control(ric), .col_idx(col)
  );

  wire [12:0] dut_vec = {busy, done, ice, cb, abs_c, cr, ric, col};

  function automatic logic [12:0] exp_vec();
    logic b = 0, d = 0, ie = 0, c = 1, a1 = 0, a0 = 0, s = 0, r = 0;
    int cc = 0, k, pass, row, area;
    if (m_active) begin
      b = 1;
      if (m_t < PRE) begin
        ie = 1;
        c  = (m_t < PRE / 2);
      end else if (m_t < TOTAL) begin
        k    = m_t - PRE;
        cc   = k / (2 * ROWS);
        pass = (k % (2 * ROWS)) / ROWS;
        row  = k % ROWS;
        r    = 1;
        c    = (pass == 0);
        a1   = (pass == 1);
        if (cc < EDGE || cc >= NCOL - EDGE) area = 1;
        else if ((cc - EDGE) % STR == 0)     area = 2;
        else                                  area = 3;
        if (area == 1) begin
          if (row < HEAD)        begin a0 = 0; s = 1; end
          else if (row >= TAILS) begin a0 = 1; s = 1; end
          else begin
`ifdef ME_SAD_DOWNSAMPLE_EN
            a0 = (row % 2 == 0); s = (row % 2 == 1);
`else
            a0 = 1; s = 1;
`endif
          end
        end else if (area == 2) begin
          a0 = (row >= HEAD); s = 1;
        end else begin
          a0 = 1; s = (row == ROWS - 1);
        end
      end else begin
        d  = 1;
        cc = NCOL - 1;
      end
    end
    return {b, d, ie, c, a1, a0, s, r, COLW'(cc)};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_active = 0; m_t = 0;
    end else if (m_active) begin
      if (abort || m_t == TOTAL) begin m_active = 0; m_t = 0; end
      else m_t++;
    end else if (start) begin
      m_active = 1; m_t = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; start = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dut_vec !== RST_VEC) begin
        errors++; $display("FAIL reset_vec cyc=%0d got=%b exp=%b", i, dut_vec, RST_VEC);
      end
    end
    rst = 0; start = 0;
    tick();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_idle got=%b exp=%b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_full_schedule();
    int n_ice = 0, n_cb_hi = 0, n_done = 0, done_at = -1, exp_cr, exp_abs;
    start = 1;
    tick();
    start = 0;
    checks++;
    if (dut_vec !== exp_vec() || ice !== 1'b1) begin
      errors++; $display("FAIL full_first got=%b exp=%b", dut_vec, exp_vec());
    end
    if (ice) begin n_ice++; if (cb) n_cb_hi++; end
    for (int n = 2; n <= TOTAL + 4; n++) begin
      start = (n == 1000);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL full_cycle n=%0d t=%0d got=%b exp=%b", n, m_t, dut_vec, exp_vec());
      end
      if (ice) begin n_ice++; if (cb) n_cb_hi++; end
      if (done) begin n_done++; done_at = n; end
      exp_cr = -1; exp_abs = -1;
      case (m_t)
        PRE + 0*76 + 9:      begin
`ifdef ME_SAD_DOWNSAMPLE_EN
                               exp_abs = 0; exp_cr = 1;
`else
                               exp_abs = 1; exp_cr = 1;
`endif
                             end
        PRE + 0*76 + 38 + 3: begin exp_abs = 2; exp_cr = 1; end
        PRE + 0*76 + 35:     begin exp_abs = 1; exp_cr = 1; end
        PRE + 8*76 + 2:      begin exp_abs = 0; exp_cr = 1; end
        PRE + 9*76 + 2:      begin exp_abs = 1; exp_cr = 0; end
        PRE + 9*76 + 37:     begin exp_abs = 1; exp_cr = 1; end
        PRE + 15*76 + 38+10: begin exp_abs = 3; exp_cr = 0; end
        PRE + 16*76 + 12:    begin exp_abs = 1; exp_cr = 1; end
        PRE + 24*76 + 3:     begin exp_abs = 0; exp_cr = 1; end
        default: ;
      endcase
      if (m_active && exp_cr >= 0) begin
        checks++;
        if (abs_c !== 2'(exp_abs) || cr !== 1'(exp_cr)) begin
          errors++; $display("FAIL row_pattern t=%0d got=%b/%b exp=%0d/%0d", m_t, abs_c, cr, exp_abs, exp_cr);
        end
      end
    end
    start = 0;
    checks++;
    if (n_ice !== PRE || n_cb_hi !== PRE / 2) begin
      errors++; $display("FAIL preload_len got=%0d/%0d exp=%0d/%0d", n_ice, n_cb_hi, PRE, PRE / 2);
    end
    checks++;
    if (n_done !== 1 || done_at !== TOTAL + 1) begin
      errors++; $display("FAIL done_timing got=%0d@%0d exp=1@%0d", n_done, done_at, TOTAL + 1);
    end
  endtask

  task automatic test_abort();
    int target = PRE + 5 * 2 * ROWS + 20, guard = 0, n_done = 0;
    start = 1;
    tick();
    start = 0;
    while (m_active && m_t < target && guard < TOTAL) begin
      tick(); guard++;
      if (done) n_done++;
    end
    checks++;
    if (col !== 5'd5 || m_t !== target) begin
      errors++; $display("FAIL abort_reach col got=%0d exp=5 t=%0d", col, m_t);
    end
    abort = 1;
    tick();
    abort = 0;
    checks++;
    if (dut_vec !== RST_VEC) begin
      errors++; $display("FAIL abort_vec got=%b exp=%b", dut_vec, RST_VEC);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) n_done++;
    end
    checks++;
    if (n_done !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_no_done got=%0d busy=%b exp=0", n_done, busy);
    end
  endtask

  task automatic test_rst_mid();
    int target = PRE + 10 * 2 * ROWS + 5, guard = 0;
    start = 1;
    tick();
    start = 0;
    while (m_active && m_t < target && guard < TOTAL) begin tick(); guard++; end
    checks++;
    if (dut_vec !== exp_vec() || ric !== 1'b1 || abs_c !== 2'b01 || cr !== 1'b0) begin
      errors++; $display("FAIL area3_entry got=%b exp=%b", dut_vec, exp_vec());
    end
    rst = 1; start = 1;
    tick();
    checks++;
    if (dut_vec !== RST_VEC) begin
      errors++; $display("FAIL rst_mid got=%b exp=%b", dut_vec, RST_VEC);
    end
    rst = 0;
    tick();
    start = 0;
    checks++;
    if (busy !== 1'b1 || ice !== 1'b1 || cb !== 1'b1 || ric !== 1'b0) begin
      errors++; $display("FAIL rst_restart got=%b exp=busy,ice,cb", dut_vec);
    end
    abort = 1;
    tick();
    abort = 0;
    checks++;
    if (dut_vec !== RST_VEC) begin
      errors++; $display("FAIL rst_cleanup got=%b exp=%b", dut_vec, RST_VEC);
    end
  endtask

  task automatic test_start_abort_idle();
    abort = 1;
    tick();
    checks++;
    if (dut_vec !== RST_VEC) begin
      errors++; $display("FAIL abort_idle got=%b exp=%b", dut_vec, RST_VEC);
    end
    start = 1;
    tick();
    start = 0; abort = 0;
    checks++;
    if (busy !== 1'b1 || ice !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL start_abort_idle got=%b exp=%b", dut_vec, exp_vec());
    end
    abort = 1;
    tick();
    abort = 0;
    checks++;
    if (dut_vec !== RST_VEC) begin
      errors++; $display("FAIL abort_pre got=%b exp=%b", dut_vec, RST_VEC);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6000; i++) begin
      start = ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 399) == 0);
      rst   = ($urandom_range(0, 1999) == 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random i=%0d t=%0d got=%b exp=%b", i, m_t, dut_vec, exp_vec());
      end
    end
    start = 0; abort = 0; rst = 0;
  endtask

  initial begin
    test_reset();
    test_full_schedule();
    test_abort();
    test_full_schedule();
    test_rst_mid();
    test_start_abort_idle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
